// File: rtl/aidc_lite_decomp_pingpong_buf_if.sv
// ----------------------------------------------------------------------------
// aidc_lite_decomp_pingpong_buf_if
// Bundle of every non-clock signal of the ping-pong output buffer.
//   slave  modport : the buffer itself (takes *_i, drives *_o)
//   master modport : decompressor channels + write-back consumer
// Handshake semantics, all on the rising edge:
//   sop_i is accepted only in a cycle where ready_o=1; an sop_i while
//   ready_o=0 is dropped and recorded in the sticky ovf_o. blk_release_i is
//   honoured only in a cycle where blk_valid_o=1, otherwise it is ignored.
// dbg_state_o = {state(bank1), state(bank0)}, 2 bits each
// (0=FREE, 1=FILL, 2=READY).
// ----------------------------------------------------------------------------
interface aidc_lite_decomp_pingpong_buf_if #(
   parameter int NUM_CH = 3,
   parameter int DATA_W = 64,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH),
   parameter int SW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   logic                     sop_i;
   logic [SW-1:0]            sel_i;
   logic                     ready_o;
   logic [NUM_CH-1:0]        ch_wren_i;
   logic [NUM_CH*AW-1:0]     ch_waddr_i;
   logic [NUM_CH*DATA_W-1:0] ch_wdata_i;
   logic [NUM_CH-1:0]        ch_done_i;
   logic [NUM_CH-1:0]        ch_fail_i;
   logic                     blk_valid_o;
   logic                     blk_fail_o;
   logic [AW-1:0]            rd_addr_i;
   logic [DATA_W-1:0]        rd_data_o;
   logic                     blk_release_i;
   logic                     ovf_o;
   logic [3:0]               dbg_state_o;

   modport slave (
      input  sop_i, sel_i, ch_wren_i, ch_waddr_i, ch_wdata_i, ch_done_i,
             ch_fail_i, rd_addr_i, blk_release_i,
      output ready_o, blk_valid_o, blk_fail_o, rd_data_o, ovf_o, dbg_state_o
   );

   modport master (
      output sop_i, sel_i, ch_wren_i, ch_waddr_i, ch_wdata_i, ch_done_i,
             ch_fail_i, rd_addr_i, blk_release_i,
      input  ready_o, blk_valid_o, blk_fail_o, rd_data_o, ovf_o, dbg_state_o
   );
endinterface

// File: rtl/aidc_lite_decomp_pingpong_buf.sv
// ----------------------------------------------------------------------------
// aidc_lite_decomp_pingpong_buf
// Double-buffered output stage of the AIDC-Lite decompression path. One
// decompressor channel (chosen per block by sel_i) fills the write bank while
// the engine reads the other bank by address.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - slave side of aidc_lite_decomp_pingpong_buf_if (block start,
//          per-channel write/done/fail strobes, read port, release, ovf,
//          per-bank state debug)
// ----------------------------------------------------------------------------
module aidc_lite_decomp_pingpong_buf #(
   parameter int NUM_CH = 3,
   parameter int DATA_W = 64,
   parameter int DEPTH  = 8
) (
   input logic                            clk,
   input logic                            rst,
   aidc_lite_decomp_pingpong_buf_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      FREE  = 2'd0,
      FILL  = 2'd1,
      READY = 2'd2
   } bank_state_e;

   bank_state_e       state_q [2];
   bank_state_e       state_d [2];
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [SW-1:0]     cur_sel_q, cur_sel_d;
   logic [1:0]        fail_q, fail_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   // Both banks in one array; the bank bit is the address MSB.
   logic [DATA_W-1:0] mem [2*DEPTH];

   logic              sel_wren;
   logic [AW-1:0]     sel_waddr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_done;
   logic              sel_fail;
   logic              fill_active;
   logic              ready;
   logic              blk_valid;
   logic              mem_we;

   // Channel mux built by comparison so a cur_sel value outside the channel
   // range simply selects nothing.
   always_comb begin
      sel_wren  = 1'b0;
      sel_waddr = '0;
      sel_wdata = '0;
      sel_done  = 1'b0;
      sel_fail  = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (cur_sel_q == SW'(k)) begin
            sel_wren  = bus.ch_wren_i[k];
            sel_waddr = bus.ch_waddr_i[k*AW +: AW];
            sel_wdata = bus.ch_wdata_i[k*DATA_W +: DATA_W];
            sel_done  = bus.ch_done_i[k];
            sel_fail  = bus.ch_fail_i[k];
         end
      end
   end

   assign fill_active = (state_q[wr_bank_q] == FILL);
   assign ready       = (state_q[wr_bank_q] == FREE);
   assign blk_valid   = (state_q[rd_bank_q] == READY);
   // Reset wins over a write so a fill cut by reset leaves no new words.
   assign mem_we      = fill_active && sel_wren && !rst;

   always_comb begin
      state_d   = state_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      cur_sel_d = cur_sel_q;
      fail_d    = fail_q;
      ovf_d     = ovf_q;
      rd_data_d = mem[{rd_bank_q, bus.rd_addr_i}];

      // Done and sop are mutually exclusive: sop needs the write bank FREE,
      // done needs it in FILL.
      if (fill_active && sel_done) begin
         state_d[wr_bank_q] = READY;
         fail_d[wr_bank_q]  = sel_fail;
         wr_bank_d          = ~wr_bank_q;
      end

      if (bus.sop_i) begin
         if (ready) begin
            cur_sel_d = bus.sel_i;
            if (int'(bus.sel_i) >= NUM_CH) begin
               // Bad channel index: publish an empty, failed block at once.
               state_d[wr_bank_q] = READY;
               fail_d[wr_bank_q]  = 1'b1;
               wr_bank_d          = ~wr_bank_q;
            end else begin
               state_d[wr_bank_q] = FILL;
            end
         end else begin
            ovf_d = 1'b1;
         end
      end

      // Release targets a READY bank, so it can never collide with the
      // FREE/FILL bank touched above.
      if (bus.blk_release_i && blk_valid) begin
         state_d[rd_bank_q] = FREE;
         rd_bank_d          = ~rd_bank_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q[0] <= FREE;
         state_q[1] <= FREE;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         cur_sel_q  <= '0;
         fail_q     <= '0;
         ovf_q      <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         cur_sel_q  <= cur_sel_d;
         fail_q     <= fail_d;
         ovf_q      <= ovf_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[{wr_bank_q, sel_waddr}] <= sel_wdata;
      end
   end

   assign bus.ready_o     = ready;
   assign bus.blk_valid_o = blk_valid;
   assign bus.blk_fail_o  = fail_q[rd_bank_q];
   assign bus.ovf_o       = ovf_q;
   assign bus.rd_data_o   = rd_data_q;
   assign bus.dbg_state_o = {state_q[1], state_q[0]};

endmodule

// File: tb/tb_aidc_lite_decomp_pingpong_buf.sv
module tb_aidc_lite_decomp_pingpong_buf;
   localparam int NUM_CH = 3;
   localparam int DW     = 64;
   localparam int DEPTH  = 8;
   localparam int AW     = $clog2(DEPTH);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aidc_lite_decomp_pingpong_buf_if #(.NUM_CH(NUM_CH), .DATA_W(DW), .DEPTH(DEPTH)) bus ();

   aidc_lite_decomp_pingpong_buf #(.NUM_CH(NUM_CH), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- reference model ----------------
   // Blocks are objects: a bank's word storage, a queue of finished blocks
   // waiting for the consumer, and at most one block being filled.
   typedef struct {
      bit bank;
      bit fail;
   } blk_t;

   logic [DW-1:0] mdl_mem   [2][DEPTH];
   bit            mdl_known [2][DEPTH];
   blk_t          pend_q[$];
   bit            mdl_filling;
   bit            mdl_fill_bank;
   int            mdl_fill_sel;
   bit            mdl_next_bank;
   bit            mdl_rd_bank;
   bit            mdl_ovf;

   // ---------------- scoreboard ----------------
   logic [DW-1:0] exp_q[$];
   bit            exp_known_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      rst               = 1'b0;
      bus.sop_i         = 1'b0;
      bus.sel_i         = '0;
      bus.ch_wren_i     = '0;
      bus.ch_waddr_i    = '0;
      bus.ch_wdata_i    = '0;
      bus.ch_done_i     = '0;
      bus.ch_fail_i     = '0;
      bus.blk_release_i = 1'b0;
   endtask

   task automatic drv_sop(input int sel);
      bus.sop_i = 1'b1;
      bus.sel_i = 2'(sel);
   endtask

   task automatic drv_wr(input int ch, input int addr, input logic [DW-1:0] data);
      bus.ch_wren_i[ch]              = 1'b1;
      bus.ch_waddr_i[ch*AW +: AW]    = AW'(addr);
      bus.ch_wdata_i[ch*DW +: DW]    = data;
   endtask

   task automatic drv_done(input int ch, input bit fail);
      bus.ch_done_i[ch] = 1'b1;
      bus.ch_fail_i[ch] = fail;
   endtask

   // Advance one clock: update the model from the inputs present before the
   // edge, then compare DUT outputs 1 time unit after the edge.
   task automatic cycle();
      bit ready_pre, valid_pre;
      int s, a;
      ready_pre = !mdl_filling && (pend_q.size() < 2);
      valid_pre = (pend_q.size() > 0);
      if (rst) begin
         exp_q.push_back('0);
         exp_known_q.push_back(1'b1);
         pend_q.delete();
         mdl_filling   = 0;
         mdl_next_bank = 0;
         mdl_rd_bank   = 0;
         mdl_ovf       = 0;
      end else begin
         exp_q.push_back(mdl_mem[mdl_rd_bank][bus.rd_addr_i]);
         exp_known_q.push_back(mdl_known[mdl_rd_bank][bus.rd_addr_i]);
         if (mdl_filling) begin
            s = mdl_fill_sel;
            if (bus.ch_wren_i[s]) begin
               a = int'(bus.ch_waddr_i[s*AW +: AW]);
               mdl_mem[mdl_fill_bank][a]   = bus.ch_wdata_i[s*DW +: DW];
               mdl_known[mdl_fill_bank][a] = 1'b1;
            end
            if (bus.ch_done_i[s]) begin
               pend_q.push_back('{bank: mdl_fill_bank, fail: bus.ch_fail_i[s]});
               mdl_filling   = 0;
               mdl_next_bank = ~mdl_next_bank;
            end
         end
         if (bus.blk_release_i && valid_pre) begin
            void'(pend_q.pop_front());
            mdl_rd_bank = ~mdl_rd_bank;
         end
         if (bus.sop_i) begin
            if (!ready_pre) begin
               mdl_ovf = 1;
            end else if (int'(bus.sel_i) >= NUM_CH) begin
               pend_q.push_back('{bank: mdl_next_bank, fail: 1'b1});
               mdl_next_bank = ~mdl_next_bank;
            end else begin
               mdl_filling   = 1;
               mdl_fill_bank = mdl_next_bank;
               mdl_fill_sel  = int'(bus.sel_i);
            end
         end
      end
      @(posedge clk);
      #1;
      chk("ready", 64'(bus.ready_o), 64'(!mdl_filling && (pend_q.size() < 2)));
      chk("blk_valid", 64'(bus.blk_valid_o), 64'(pend_q.size() > 0));
      chk("ovf", 64'(bus.ovf_o), 64'(mdl_ovf));
      if (pend_q.size() > 0) chk("blk_fail", 64'(bus.blk_fail_o), 64'(pend_q[0].fail));
      begin
         logic [DW-1:0] e;
         bit            k;
         e = exp_q.pop_front();
         k = exp_known_q.pop_front();
         if (k) chk("rd_data", bus.rd_data_o, e);
      end
      idle();
   endtask

   task automatic fill_block(input int sel, input bit fail);
      drv_sop(sel);
      cycle();
      for (int a = 0; a < DEPTH; a++) begin
         drv_wr(sel, a, {$urandom, $urandom});
         cycle();
      end
      drv_done(sel, fail);
      cycle();
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a++) begin
         bus.rd_addr_i = AW'(a);
         cycle();
      end
   endtask

   task automatic release_blk();
      bus.blk_release_i = 1'b1;
      cycle();
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      idle();
      bus.rd_addr_i = '0;
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < DEPTH; a++) mdl_known[b][a] = 1'b0;

      // Reset state
      rst = 1'b1;
      cycle();
      chk("reset_ready", 64'(bus.ready_o), 64'd1);
      chk("reset_rd_data", bus.rd_data_o, 64'd0);

      // Basic block on channel 1, with ch0/ch2 writes to addr 3 that must be ignored
      drv_sop(1);
      cycle();
      for (int a = 0; a < DEPTH; a++) begin
         drv_wr(1, a, 64'h10 + 64'(a));
         if (a == 3) begin
            drv_wr(0, 3, 64'hDEAD);
            drv_wr(2, 3, 64'hDEAD);
         end
         cycle();
      end
      drv_done(1, 1'b0);
      cycle();
      chk("basic_valid", 64'(bus.blk_valid_o), 64'd1);
      chk("basic_fail", 64'(bus.blk_fail_o), 64'd0);
      for (int a = 0; a < DEPTH; a++) begin
         bus.rd_addr_i = AW'(a);
         cycle();
         chk("basic_read", bus.rd_data_o, 64'h10 + 64'(a));
      end
      release_blk();

      // Ping-pong: two blocks back to back, then an overflowing sop
      fill_block(0, 1'b0);
      fill_block(2, 1'b0);
      chk("pp_ready_low", 64'(bus.ready_o), 64'd0);
      chk("pp_no_ovf", 64'(bus.ovf_o), 64'd0);
      drv_sop(1);
      cycle();
      chk("pp_ovf", 64'(bus.ovf_o), 64'd1);
      read_all();
      release_blk();
      chk("pp_valid_after_rel", 64'(bus.blk_valid_o), 64'd1);
      chk("pp_ready_after_rel", 64'(bus.ready_o), 64'd1);
      read_all();
      release_blk();

      // Same-cycle done and release
      fill_block(0, 1'b0);
      drv_sop(1);
      cycle();
      for (int a = 0; a < DEPTH; a++) begin
         drv_wr(1, a, {$urandom, $urandom});
         cycle();
      end
      drv_done(1, 1'b0);
      bus.blk_release_i = 1'b1;
      cycle();
      chk("same_valid", 64'(bus.blk_valid_o), 64'd1);
      chk("same_ready", 64'(bus.ready_o), 64'd1);
      read_all();
      release_blk();

      // Out-of-range select and a failed block
      drv_sop(3);
      cycle();
      chk("badsel_valid", 64'(bus.blk_valid_o), 64'd1);
      chk("badsel_fail", 64'(bus.blk_fail_o), 64'd1);
      release_blk();
      fill_block(2, 1'b1);
      chk("chfail_fail", 64'(bus.blk_fail_o), 64'd1);
      release_blk();

      // Reset in the middle of a fill
      drv_sop(0);
      cycle();
      for (int a = 0; a < 4; a++) begin
         drv_wr(0, a, {$urandom, $urandom});
         cycle();
      end
      rst = 1'b1;
      cycle();
      chk("midrst_ready", 64'(bus.ready_o), 64'd1);
      chk("midrst_valid", 64'(bus.blk_valid_o), 64'd0);
      drv_wr(0, 5, 64'hBAD);
      drv_done(0, 1'b0);
      cycle();
      chk("midrst_done_ignored", 64'(bus.blk_valid_o), 64'd0);

      // Randomised traffic against the model
      for (int i = 0; i < 800; i++) begin
         bus.rd_addr_i = AW'($urandom_range(0, DEPTH - 1));
         if ($urandom_range(0, 7) == 0) drv_sop($urandom_range(0, 3));
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if ($urandom_range(0, 1) == 1) drv_wr(ch, $urandom_range(0, DEPTH - 1), {$urandom, $urandom});
            if ($urandom_range(0, 11) == 0) drv_done(ch, 1'($urandom_range(0, 1)));
         end
         if ($urandom_range(0, 5) == 0) bus.blk_release_i = 1'b1;
         if ($urandom_range(0, 299) == 0) rst = 1'b1;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/aidc_lite_decomp_pingpong_buf.md
# aidc_lite_decomp_pingpong_buf

Parametrised, double-buffered output stage for the AIDC-Lite decompression path. It takes write streams from NUM_CH decompressor channels, routes the channel selected per block into one of two block banks, and presents completed blocks to the engine's write-back side by address. Because two banks alternate, channel k can fill bank B while the engine drains bank A. It also carries a per-block fail flag and a sticky overflow indicator.

## Interface
Parameters:
- NUM_CH, 3: number of decompressor channels; must be at least 1.
- DATA_W, 64: word width in bits.
- DEPTH, 8: words per block bank; must be a power of 2 and at least 2. AW = $clog2(DEPTH).
- SW, (NUM_CH>1 ? $clog2(NUM_CH) : 1): width of the channel-select field.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sop_i  in  1  start of block; sel_i is sampled when sop_i is accepted.
- sel_i  in  SW  channel index for the block being started.
- ready_o  out  1  a free bank is available and no fill is in progress.
- ch_wren_i  in  NUM_CH  per-channel write strobe.
- ch_waddr_i  in  NUM_CH*AW  per-channel word address; channel k occupies bits [k*AW +: AW].
- ch_wdata_i  in  NUM_CH*DATA_W  per-channel write data; channel k occupies bits [k*DATA_W +: DATA_W].
- ch_done_i  in  NUM_CH  per-channel end-of-block pulse.
- ch_fail_i  in  NUM_CH  per-channel fail flag; only meaningful together with done.
- blk_valid_o  out  1  read bank holds a completed block.
- blk_fail_o  out  1  fail flag of the read bank; valid while blk_valid_o=1.
- rd_addr_i  in  AW  read word address.
- rd_data_o  out  DATA_W  registered read data.
- blk_release_i  in  1  consumer is finished with the read bank.
- ovf_o  out  1  sticky flag: an sop_i arrived while ready_o=0.

## Operation
- Each bank has a 2-bit state: FREE, FILL or READY. Supporting registers:
  - wr_bank and rd_bank pointers (1 bit each);
  - cur_sel, the latched channel for the current fill;
  - fail[1:0], one fail bit per bank.
- ready_o = (state[wr_bank]==FREE). This is decoded from registered state only.
- sop_i with ready_o=1 is accepted:
  - state[wr_bank] becomes FILL and cur_sel <= sel_i.
  - If sel_i >= NUM_CH, the bank goes directly to READY with fail=1, wr_bank toggles, and no words are written.
- sop_i with ready_o=0 is ignored and sets ovf_o.
- While state[wr_bank]==FILL:
  - ch_wren_i[cur_sel] writes ch_wdata_i[cur_sel] at ch_waddr_i[cur_sel] in bank wr_bank.
  - Strobes from every other channel are ignored.
- ch_done_i[cur_sel] while in FILL:
  - state becomes READY and fail[wr_bank] <= ch_fail_i[cur_sel].
  - wr_bank toggles.
  - A wren in the same cycle as done is still written.
- ch_done_i from a non-selected channel, or while no bank is in FILL, is ignored.
- Words a channel does not write keep their stale contents; the buffer does not clear banks.
- Read side:
  - blk_valid_o = (state[rd_bank]==READY) and blk_fail_o = fail[rd_bank].
  - rd_data_o <= mem[rd_bank][rd_addr_i] every cycle, regardless of bank state.
- blk_release_i while blk_valid_o=1: state[rd_bank] becomes FREE and rd_bank toggles.
- blk_release_i while blk_valid_o=0 is ignored.
- Same-cycle events:
  - Done on wr_bank and release on rd_bank in the same cycle are both applied.
  - If release frees the bank that wr_bank points to, ready_o rises the following cycle. An sop_i in the release cycle itself is treated as ovf.
- Reset behaviour:
  - Both banks go FREE; wr_bank, rd_bank, cur_sel, fail and ovf_o go to 0; rd_data_o goes to 0.
  - Memory contents are not reset.
  - Reset during a fill drops the partial block. Channel strobes after reset are ignored until an accepted sop_i.

## Timing
- Output values after a reset edge: ready_o=1, blk_valid_o=0, blk_fail_o=0, ovf_o=0, rd_data_o=0.
- sop_i accepted at edge N: channel writes are taken from cycle N+1. A write in cycle N itself is ignored.
- Done at edge N: blk_valid_o=1 in cycle N+1 if that bank is rd_bank. The first read returns data at edge N+2.
- Read latency is 1 cycle: rd_addr_i presented at edge N gives rd_data_o valid after edge N+1.
- Throughput with release issued the same cycle as the last read: one block per DEPTH+2 cycles per bank.
- Both banks READY: ready_o=0 until one release, and ready_o is 1 in the cycle after that release.

## Test plan
- Reset, then sop with sel=1; ch1 writes addr 0..7 with data 0x10..0x17; ch1 done with fail=0. Expected: blk_valid_o=1 one cycle later; reads of addr 0..7 return 0x10..0x17 with 1-cycle latency; blk_fail_o=0.
- During that fill, ch0 and ch2 write addr 3 with 0xDEAD. Expected: addr 3 still reads 0x13.
- Ping-pong: fill block A (sel=0) and block B (sel=2) back to back without release. Expected: ready_o=0 and ovf_o stays 0. Then a third sop. Expected: ovf_o=1 (sticky). Release A. Expected: blk_valid_o stays 1 and reads return B's data; ready_o=1 next cycle.
- Same-cycle done and release: bank0 READY while bank1 is FILL; ch done and blk_release_i in the same cycle. Expected: bank1 readable next cycle, bank0 FREE, ready_o=1.
- Sop with sel=3 (NUM_CH=3). Expected: blk_valid_o=1 and blk_fail_o=1 next cycle, no writes. Separately, ch done with fail=1. Expected: blk_fail_o=1.
- Assert rst mid-fill after 4 writes. Expected: ready_o=1 and blk_valid_o=0 after the reset edge; a later ch done is ignored.
